// File: rtl/mgt_01_mul_pipe_pkg.sv
// Shared types and helpers for the MicroGT pipelined multiplier.
//
// Contents:
//   mul_ops_e   - RV32M multiply operation select. The encoding matches the
//                 existing enum so that current decoders keep working.
//   mul_stage_t - the bundle handed from one accumulation stage to the next.
//                 Fields are sized for the widest supported configuration.
//                 Each stage reads and writes only the low bits that match
//                 its own XLEN/TAG_W, and zero-fills the rest.
//   mul_slice_w - the number of multiplier bits handled by each stage.
package mgt_01_mul_pipe_pkg;

  localparam int MUL_XLEN_MAX  = 64;
  localparam int MUL_TAG_W_MAX = 16;

  typedef enum logic [1:0] {
    MUL_    = 2'b00,
    MULH_   = 2'b01,
    MULHSU_ = 2'b10,
    MULHU_  = 2'b11
  } mul_ops_e;

  // Operands are stored already extended to XLEN+1 bits.
  // The accumulator is 2*XLEN+2 bits wide and holds a two's-complement value.
  typedef struct packed {
    logic                         valid;
    mul_ops_e                     ops;
    logic [MUL_TAG_W_MAX-1:0]     tag;
    logic [MUL_XLEN_MAX:0]        multiplicand;
    logic [MUL_XLEN_MAX:0]        multiplier;
    logic [2*MUL_XLEN_MAX+1:0]    acc;
  } mul_stage_t;

  function automatic int mul_slice_w(input int xlen, input int stages);
    return xlen / stages;
  endfunction

endpackage

// File: rtl/mgt_01_mul_stage.sv
// One accumulation stage of the pipelined multiplier.
//
// Stage IDX adds the partial products for multiplier bits
// [IDX*S, IDX*S+S-1] to the incoming accumulator. The last stage also
// handles the extension bit of the multiplier, which has negative weight in
// a two's-complement XLEN+1 bit operand.
//
// The stage registers the updated accumulator, the operands, the operation,
// the tag and a valid bit.
//
// Ports:
//   clk_i, rst_n_i - clock and asynchronous active-low reset
//   clk_en_i       - low holds every register of the stage
//   flush_i        - clears the valid bit whatever the state of clk_en_i
//   stage_i        - bundle from the previous stage (or from operand extension)
//   stage_o        - registered bundle for the next stage
module mgt_01_mul_stage
  import mgt_01_mul_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4,
  parameter int IDX    = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clk_en_i,
  input  logic       flush_i,
  input  mul_stage_t stage_i,
  output mul_stage_t stage_o
);

  localparam int  S     = mul_slice_w(XLEN, STAGES);
  localparam int  ACC_W = 2*XLEN + 2;
  localparam bit  LAST  = (IDX == STAGES-1);

  logic [XLEN:0]      w_mcand;
  logic [XLEN:0]      w_mplier;
  logic [ACC_W-1:0]   w_acc_in;
  logic [ACC_W-1:0]   w_mcand_ext;
  logic [ACC_W-1:0]   w_acc_next;

  logic               r_valid;
  mul_ops_e           r_ops;
  logic [TAG_W-1:0]   r_tag;
  logic [XLEN:0]      r_mcand;
  logic [XLEN:0]      r_mplier;
  logic [ACC_W-1:0]   r_acc;

  assign w_mcand     = stage_i.multiplicand[XLEN:0];
  assign w_mplier    = stage_i.multiplier[XLEN:0];
  assign w_acc_in    = stage_i.acc[ACC_W-1:0];
  assign w_mcand_ext = {{(ACC_W-XLEN-1){w_mcand[XLEN]}}, w_mcand};

  // The multiplier's top (extension) bit carries weight -2^XLEN. It is 1 only
  // for a sign-extended negative operand, so subtracting whenever it is set
  // covers both the signed and the unsigned cases.
  always_comb begin
    w_acc_next = w_acc_in;
    for (int j = 0; j < S; j++) begin
      if (w_mplier[IDX*S + j]) begin
        w_acc_next = w_acc_next + (w_mcand_ext << (IDX*S + j));
      end
    end
    if (LAST && w_mplier[XLEN]) begin
      w_acc_next = w_acc_next - (w_mcand_ext << XLEN);
    end
  end

  // Datapath registers load only for a valid operation. The last stage then
  // keeps the most recent result visible while valid_o is low.
  // Flush kills the valid bit even while the pipeline is stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid  <= 1'b0;
      r_ops    <= MUL_;
      r_tag    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (flush_i) begin
      r_valid  <= 1'b0;
    end else if (clk_en_i) begin
      r_valid <= stage_i.valid;
      if (stage_i.valid) begin
        r_ops    <= stage_i.ops;
        r_tag    <= stage_i.tag[TAG_W-1:0];
        r_mcand  <= w_mcand;
        r_mplier <= w_mplier;
        r_acc    <= w_acc_next;
      end
    end
  end

  always_comb begin
    stage_o                        = '0;
    stage_o.valid                  = r_valid;
    stage_o.ops                    = r_ops;
    stage_o.tag[TAG_W-1:0]         = r_tag;
    stage_o.multiplicand[XLEN:0]   = r_mcand;
    stage_o.multiplier[XLEN:0]     = r_mplier;
    stage_o.acc[ACC_W-1:0]         = r_acc;
  end

endmodule

// File: rtl/mgt_01_mul_pipe.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the MicroGT
// execute stage.
//
// The operands are extended to XLEN+1 bits according to the operation. Then
// STAGES accumulation stages each add one slice of partial products. Valid
// and tag travel alongside. The last stage selects the low or high half of
// the product.
//
// Ports:
//   clk_i, rst_n_i   - clock and asynchronous active-low reset
//   clk_en_i         - stage enable; low freezes the whole pipeline
//   flush_i          - kill every in-flight operation (and the one on valid_i)
//   valid_i          - operation present on ops_i/multiplicand_i/multiplier_i
//   ops_i            - operation select
//   multiplicand_i   - rs1
//   multiplier_i     - rs2
//   tag_i            - issue tag
//   valid_o          - result_o/tag_o valid
//   result_o         - selected XLEN-bit half of the product
//   tag_o            - tag of the operation on result_o
//   busy_o           - any stage holds a valid operation
module mgt_01_mul_pipe
  import mgt_01_mul_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clk_en_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  mul_ops_e          ops_i,
  input  logic [XLEN-1:0]   multiplicand_i,
  input  logic [XLEN-1:0]   multiplier_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

  mul_stage_t w_stage_in;
  mul_stage_t w_stage_out [STAGES];
  mul_stage_t w_last;
  logic       w_mcand_sign;
  logic       w_mplier_sign;

  // The operand sign bits are used only for MULH_ and MULHSU_. MUL_ takes the
  // low half, which does not depend on the extension, so it is zero-extended.
  always_comb begin
    w_mcand_sign  = 1'b0;
    w_mplier_sign = 1'b0;
    case (ops_i)
      MULH_: begin
        w_mcand_sign  = multiplicand_i[XLEN-1];
        w_mplier_sign = multiplier_i[XLEN-1];
      end
      MULHSU_: begin
        w_mcand_sign  = multiplicand_i[XLEN-1];
      end
      default: begin
        w_mcand_sign  = 1'b0;
        w_mplier_sign = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_stage_in                      = '0;
    w_stage_in.valid                = valid_i;
    w_stage_in.ops                  = ops_i;
    w_stage_in.tag[TAG_W-1:0]       = tag_i;
    w_stage_in.multiplicand[XLEN:0] = {w_mcand_sign, multiplicand_i};
    w_stage_in.multiplier[XLEN:0]   = {w_mplier_sign, multiplier_i};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mul_stage_t w_prev;
    if (k == 0) begin : g_first
      assign w_prev = w_stage_in;
    end else begin : g_next
      assign w_prev = w_stage_out[k-1];
    end

    mgt_01_mul_stage #(
      .XLEN   (XLEN),
      .STAGES (STAGES),
      .TAG_W  (TAG_W),
      .IDX    (k)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clk_en_i (clk_en_i),
      .flush_i  (flush_i),
      .stage_i  (w_prev),
      .stage_o  (w_stage_out[k])
    );
  end

  assign w_last = w_stage_out[STAGES-1];

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy_o = busy_o | w_stage_out[k].valid;
    end
  end

  assign valid_o  = w_last.valid;
  assign tag_o    = w_last.tag[TAG_W-1:0];
  assign result_o = (w_last.ops == MUL_) ? w_last.acc[XLEN-1:0]
                                         : w_last.acc[2*XLEN-1:XLEN];

endmodule
